// File: rtl/bms_meas_sequencer.sv
// Periodic three-cell measurement scheduler: shares one ADC via req/ack, publishes a
// coherent voltage/SOC set with a one-cycle strobe, and tracks UV and ADC-timeout faults.
module bms_meas_sequencer #(
  parameter int          SAMPLE_PERIOD = 1000,
  parameter int          ADC_TIMEOUT   = 64,
  parameter logic [11:0] UV_THRESH     = 12'd2800,
  parameter int          UV_DEBOUNCE   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        adc_req,
  output logic [1:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  input  logic [7:0]  soc_percent,
  output logic [11:0] cell_1_voltage,
  output logic [11:0] cell_2_voltage,
  output logic [11:0] cell_3_voltage,
  output logic [7:0]  soc_latched,
  output logic        sample_valid,
  output logic        uv_fault,
  output logic        adc_timeout_fault,
  output logic [15:0] scan_count,
  output logic [2:0]  dbg_state
);

  localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int TO_W  = $clog2(ADC_TIMEOUT + 1);

  // Handshake: adc_req rises one cycle after REQ is entered and stays high, with adc_ch
  // stable, until the first cycle adc_ack=1 is seen (or the timeout expires); it drops on
  // that same edge. adc_ack is only meaningful while adc_req=1.
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_PERIOD = 3'd1,
    S_REQ         = 3'd2,
    S_WAIT_ACK    = 3'd3,
    S_PUBLISH     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]        uv_cnt_q, uv_cnt_d;
  logic              adc_req_q, adc_req_d;
  logic [1:0]        adc_ch_q, adc_ch_d;
  logic [11:0]       shadow_q [3];
  logic [11:0]       shadow_d [3];
  logic [11:0]       cell1_q, cell1_d, cell2_q, cell2_d, cell3_q, cell3_d;
  logic [7:0]        soc_q, soc_d;
  logic              sample_valid_q, sample_valid_d;
  logic              uv_fault_q, uv_fault_d;
  logic              to_fault_q, to_fault_d;
  logic [15:0]       scan_q, scan_d;

  logic              uv_hit;
  logic [3:0]        uv_cnt_inc;

  assign uv_hit     = (shadow_q[0] < UV_THRESH) || (shadow_q[1] < UV_THRESH) ||
                      (shadow_q[2] < UV_THRESH);
  assign uv_cnt_inc = (uv_cnt_q == 4'(UV_DEBOUNCE)) ? uv_cnt_q : uv_cnt_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    timer_d        = timer_q;
    to_cnt_d       = to_cnt_q;
    uv_cnt_d       = uv_cnt_q;
    adc_req_d      = adc_req_q;
    adc_ch_d       = adc_ch_q;
    shadow_d       = shadow_q;
    cell1_d        = cell1_q;
    cell2_d        = cell2_q;
    cell3_d        = cell3_q;
    soc_d          = soc_q;
    sample_valid_d = 1'b0;
    uv_fault_d     = uv_fault_q;
    to_fault_d     = to_fault_q;
    scan_d         = scan_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (enable) begin
          state_d = S_REQ;
          ch_d    = 2'd0;
        end
      end

      S_WAIT_PERIOD: begin
        if (!enable) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == TMR_W'(SAMPLE_PERIOD - 1)) begin
          state_d = S_REQ;
          timer_d = '0;
          ch_d    = 2'd0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_REQ: begin
        adc_req_d = 1'b1;
        adc_ch_d  = ch_q;
        to_cnt_d  = '0;
        state_d   = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        // An ack on the expiry cycle takes priority over the abort.
        if (adc_req_q && adc_ack) begin
          case (ch_q)
            2'd0:    shadow_d[0] = adc_data;
            2'd1:    shadow_d[1] = adc_data;
            default: shadow_d[2] = adc_data;
          endcase
          adc_req_d = 1'b0;
          to_cnt_d  = '0;
          if (ch_q == 2'd2) begin
            state_d = S_PUBLISH;
          end else begin
            state_d = S_REQ;
            ch_d    = ch_q + 2'd1;
          end
        end else if (to_cnt_q == TO_W'(ADC_TIMEOUT - 1)) begin
          adc_req_d  = 1'b0;
          to_fault_d = 1'b1;
          to_cnt_d   = '0;
          timer_d    = '0;
          state_d    = S_WAIT_PERIOD;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_PUBLISH: begin
        cell1_d        = shadow_q[0];
        cell2_d        = shadow_q[1];
        cell3_d        = shadow_q[2];
        soc_d          = soc_percent;
        sample_valid_d = 1'b1;
        scan_d         = scan_q + 16'd1;
        to_fault_d     = 1'b0;
        if (uv_hit) begin
          uv_cnt_d   = uv_cnt_inc;
          uv_fault_d = (uv_cnt_inc == 4'(UV_DEBOUNCE));
        end else begin
          uv_cnt_d   = 4'd0;
          uv_fault_d = 1'b0;
        end
        timer_d = '0;
        state_d = S_WAIT_PERIOD;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ch_q           <= '0;
      timer_q        <= '0;
      to_cnt_q       <= '0;
      uv_cnt_q       <= '0;
      adc_req_q      <= 1'b0;
      adc_ch_q       <= '0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
      cell1_q        <= '0;
      cell2_q        <= '0;
      cell3_q        <= '0;
      soc_q          <= '0;
      sample_valid_q <= 1'b0;
      uv_fault_q     <= 1'b0;
      to_fault_q     <= 1'b0;
      scan_q         <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      timer_q        <= timer_d;
      to_cnt_q       <= to_cnt_d;
      uv_cnt_q       <= uv_cnt_d;
      adc_req_q      <= adc_req_d;
      adc_ch_q       <= adc_ch_d;
      shadow_q       <= shadow_d;
      cell1_q        <= cell1_d;
      cell2_q        <= cell2_d;
      cell3_q        <= cell3_d;
      soc_q          <= soc_d;
      sample_valid_q <= sample_valid_d;
      uv_fault_q     <= uv_fault_d;
      to_fault_q     <= to_fault_d;
      scan_q         <= scan_d;
    end
  end

  assign adc_req           = adc_req_q;
  assign adc_ch            = adc_ch_q;
  assign cell_1_voltage    = cell1_q;
  assign cell_2_voltage    = cell2_q;
  assign cell_3_voltage    = cell3_q;
  assign soc_latched       = soc_q;
  assign sample_valid      = sample_valid_q;
  assign uv_fault          = uv_fault_q;
  assign adc_timeout_fault = to_fault_q;
  assign scan_count        = scan_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_bms_meas_sequencer.sv
// Bench for bms_meas_sequencer: directed scan table, hand-written corner sequences and
// randomized scans checked against a scan-level reference model and publish scoreboard.
module tb_bms_meas_sequencer;

  localparam int          SP   = 8;
  localparam int          TO   = 6;
  localparam logic [11:0] THR  = 12'd2800;
  localparam int          DEB  = 3;
  localparam int          WLIM = 4 * SP + 20;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        adc_req;
  logic [1:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic [7:0]  soc_percent;
  logic [11:0] cell_1_voltage, cell_2_voltage, cell_3_voltage;
  logic [7:0]  soc_latched;
  logic        sample_valid;
  logic        uv_fault;
  logic        adc_timeout_fault;
  logic [15:0] scan_count;
  logic [2:0]  dbg_state;

  bms_meas_sequencer #(
    .SAMPLE_PERIOD(SP), .ADC_TIMEOUT(TO), .UV_THRESH(THR), .UV_DEBOUNCE(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
    .soc_percent(soc_percent),
    .cell_1_voltage(cell_1_voltage), .cell_2_voltage(cell_2_voltage),
    .cell_3_voltage(cell_3_voltage), .soc_latched(soc_latched),
    .sample_valid(sample_valid), .uv_fault(uv_fault),
    .adc_timeout_fault(adc_timeout_fault), .scan_count(scan_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model + scoreboard ----------------
  logic [11:0] m_cell [3];
  logic [7:0]  m_soc;
  logic [15:0] m_scan;
  int          m_uv_cnt;
  logic        m_uv;
  logic        m_fault;
  logic [43:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cell[i] = '0;
    m_soc = '0; m_scan = '0; m_uv_cnt = 0; m_uv = 1'b0; m_fault = 1'b0;
    exp_q.delete();
  endtask

  // A scan that published: UV history counts consecutive low scans, saturating.
  task automatic model_publish(input logic [11:0] d0, d1, d2, input logic [7:0] soc);
    bit low;
    m_cell[0] = d0; m_cell[1] = d1; m_cell[2] = d2;
    m_soc  = soc;
    m_scan = m_scan + 16'd1;
    m_fault = 1'b0;
    low = (d0 < THR) || (d1 < THR) || (d2 < THR);
    if (low) begin
      m_uv_cnt = (m_uv_cnt + 1 > DEB) ? DEB : m_uv_cnt + 1;
      m_uv     = (m_uv_cnt == DEB);
    end else begin
      m_uv_cnt = 0;
      m_uv     = 1'b0;
    end
    exp_q.push_back({d0, d1, d2, soc});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Publish monitor and adc_ch stability monitor.
  initial begin : monitor
    logic       prev_req;
    logic [1:0] prev_ch;
    logic [43:0] e;
    prev_req = 1'b0;
    prev_ch  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && sample_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_valid actual=1 required=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if ({cell_1_voltage, cell_2_voltage, cell_3_voltage, soc_latched} !== e) begin
            errors++;
            $display("FAIL sb_publish actual=%h required=%h at %0t",
                     {cell_1_voltage, cell_2_voltage, cell_3_voltage, soc_latched}, e, $time);
          end
        end
      end
      if (rst_n && adc_req && prev_req) begin
        checks++;
        if (adc_ch !== prev_ch) begin
          errors++;
          $display("FAIL ch_stable actual=%0d required=%0d at %0t", adc_ch, prev_ch, $time);
        end
      end
      prev_req = adc_req;
      prev_ch  = adc_ch;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!adc_req && n < WLIM) begin
      tick();
      n++;
    end
    ok = adc_req;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_req actual=0 required=1 at %0t", $time);
    end
  endtask

  // One scan as seen by the ADC. lat = cycles of adc_req high before the ack;
  // miss = channel left unacknowledged (-1 for none); drop_en drops enable on ch0.
  task automatic run_scan(input logic [11:0] d0, d1, d2, input logic [7:0] soc,
                          input int lat, input int miss, input bit drop_en);
    logic [11:0] d [3];
    bit ok;
    int n;
    d[0] = d0; d[1] = d1; d[2] = d2;
    soc_percent = soc;
    for (int ch = 0; ch < 3; ch++) begin
      wait_req(ok);
      if (!ok) return;
      chk("adc_ch", 32'(adc_ch), 32'(ch));
      if (drop_en && ch == 0) enable = 1'b0;
      if (ch == miss) begin
        n = 0;
        while (adc_req && n < TO + 4) begin
          tick();
          n++;
        end
        chk("timeout_len", n, TO);
        m_fault = 1'b1;
        return;
      end
      for (int k = 0; k < lat; k++) tick();
      chk("req_held", 32'(adc_req), 1);
      if (ch == 2) model_publish(d[0], d[1], d[2], soc);
      adc_ack  = 1'b1;
      adc_data = d[ch];
      tick();
      adc_ack  = 1'b0;
      adc_data = 12'($urandom);
      chk("req_drop", 32'(adc_req), 0);
    end
    tick();
    chk("sv_latency", 32'(sample_valid), 1);
  endtask

  task automatic check_outputs(input string tag, input logic [11:0] c1, c2, c3,
                               input logic [7:0] soc, input logic uv, input logic flt,
                               input logic [15:0] sc);
    chk({tag, "_cell1"}, 32'(cell_1_voltage), 32'(c1));
    chk({tag, "_cell2"}, 32'(cell_2_voltage), 32'(c2));
    chk({tag, "_cell3"}, 32'(cell_3_voltage), 32'(c3));
    chk({tag, "_soc"}, 32'(soc_latched), 32'(soc));
    chk({tag, "_uv"}, 32'(uv_fault), 32'(uv));
    chk({tag, "_tofault"}, 32'(adc_timeout_fault), 32'(flt));
    chk({tag, "_scan"}, 32'(scan_count), 32'(sc));
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, m_cell[0], m_cell[1], m_cell[2], m_soc, m_uv, m_fault, m_scan);
  endtask

  function automatic logic [11:0] rand_mv();
    if ($urandom_range(0, 2) == 0) return 12'(2790 + $urandom_range(0, 20));
    return 12'($urandom_range(1500, 4095));
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [11:0] d0, d1, d2;
    logic [7:0]  soc;
    int          lat;
    int          miss;
    logic [11:0] e1, e2, e3;
    logic [7:0]  esoc;
    logic        euv;
    logic        efault;
    logic [15:0] escan;
  } vec_t;

  vec_t vecs [15];

  initial begin : main
    int n;
    vecs[0]  = '{12'd3700, 12'd3650, 12'd3600, 8'd80, 2, -1, 12'd3700, 12'd3650, 12'd3600, 8'd80, 1'b0, 1'b0, 16'd1};
    vecs[1]  = '{12'd3700, 12'd2799, 12'd3600, 8'd79, 1, -1, 12'd3700, 12'd2799, 12'd3600, 8'd79, 1'b0, 1'b0, 16'd2};
    vecs[2]  = '{12'd3700, 12'd2799, 12'd3600, 8'd78, 2, -1, 12'd3700, 12'd2799, 12'd3600, 8'd78, 1'b0, 1'b0, 16'd3};
    vecs[3]  = '{12'd3700, 12'd2799, 12'd3600, 8'd77, 0, -1, 12'd3700, 12'd2799, 12'd3600, 8'd77, 1'b1, 1'b0, 16'd4};
    vecs[4]  = '{12'd3700, 12'd2800, 12'd3600, 8'd76, 1, -1, 12'd3700, 12'd2800, 12'd3600, 8'd76, 1'b0, 1'b0, 16'd5};
    vecs[5]  = '{12'd2799, 12'd3700, 12'd3700, 8'd60, 0, -1, 12'd2799, 12'd3700, 12'd3700, 8'd60, 1'b0, 1'b0, 16'd6};
    vecs[6]  = '{12'd3000, 12'd3000, 12'd2000, 8'd61, 3, -1, 12'd3000, 12'd3000, 12'd2000, 8'd61, 1'b0, 1'b0, 16'd7};
    vecs[7]  = '{12'd3000, 12'd3000, 12'd3000, 8'd62, 1, -1, 12'd3000, 12'd3000, 12'd3000, 8'd62, 1'b0, 1'b0, 16'd8};
    vecs[8]  = '{12'd2000, 12'd3000, 12'd3000, 8'd63, 1, -1, 12'd2000, 12'd3000, 12'd3000, 8'd63, 1'b0, 1'b0, 16'd9};
    vecs[9]  = '{12'd1000, 12'd1000, 12'd1000, 8'd90, 1,  1, 12'd2000, 12'd3000, 12'd3000, 8'd63, 1'b0, 1'b1, 16'd9};
    vecs[10] = '{12'd2500, 12'd2500, 12'd2500, 8'd91, TO-1, -1, 12'd2500, 12'd2500, 12'd2500, 8'd91, 1'b0, 1'b0, 16'd10};
    vecs[11] = '{12'd2500, 12'd2500, 12'd2500, 8'd92, 0, -1, 12'd2500, 12'd2500, 12'd2500, 8'd92, 1'b1, 1'b0, 16'd11};
    vecs[12] = '{12'd2500, 12'd2500, 12'd2500, 8'd93, 4, -1, 12'd2500, 12'd2500, 12'd2500, 8'd93, 1'b1, 1'b0, 16'd12};
    vecs[13] = '{12'd100,  12'd100,  12'd100,  8'd94, 0,  0, 12'd2500, 12'd2500, 12'd2500, 8'd93, 1'b1, 1'b1, 16'd12};
    vecs[14] = '{12'd3300, 12'd3300, 12'd3300, 8'd95, 3, -1, 12'd3300, 12'd3300, 12'd3300, 8'd95, 1'b0, 1'b0, 16'd13};

    rst_n = 1'b0; enable = 1'b0; adc_ack = 1'b0; adc_data = '0; soc_percent = '0;
    model_reset();
    tick(); tick();
    chk("rst_req", 32'(adc_req), 0);
    chk("rst_ch", 32'(adc_ch), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    check_outputs("rst", '0, '0, '0, '0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", 32'(adc_req), 0);
    enable = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_scan(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].soc, vecs[i].lat, vecs[i].miss, 1'b0);
      check_outputs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3,
                    vecs[i].esoc, vecs[i].euv, vecs[i].efault, vecs[i].escan);
      if (i == 0) begin
        // Period from the sample_valid cycle to the next adc_req.
        n = 0;
        while (!adc_req && n < WLIM) begin
          tick();
          n++;
        end
        chk("period", n, SP + 1);
      end
    end

    // Stray acks while waiting for the next period.
    for (int k = 0; k < 3; k++) begin
      adc_ack = 1'b1; adc_data = 12'd111;
      tick();
      chk("stray_no_req", 32'(adc_req), 0);
    end
    adc_ack = 1'b0;
    check_model("stray");
    run_scan(12'd3100, 12'd3200, 12'd3300, 8'd50, 1, -1, 1'b0);
    check_model("after_stray");

    // Enable dropped mid-scan: scan completes, then no further requests.
    run_scan(12'd3400, 12'd3500, 12'd2600, 8'd40, 2, -1, 1'b1);
    check_model("en_drop");
    n = 0;
    for (int k = 0; k < 3 * SP; k++) begin
      tick();
      if (adc_req) n++;
    end
    chk("en_drop_idle", n, 0);
    enable = 1'b1;
    run_scan(12'd3500, 12'd3500, 12'd3500, 8'd41, 0, -1, 1'b0);
    check_model("en_resume");

    // Randomized scans with occasional timeouts and stray acks.
    for (int r = 0; r < 30; r++) begin
      int miss;
      miss = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_scan(rand_mv(), rand_mv(), rand_mv(), 8'($urandom_range(0, 100)),
               int'($urandom_range(0, TO - 1)), miss, 1'b0);
      check_model($sformatf("rand%0d", r));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        adc_ack = 1'b1; adc_data = 12'($urandom);
        tick();
        adc_ack = 1'b0;
      end
    end

    // Asynchronous reset in the middle of a handshake.
    begin
      bit ok;
      wait_req(ok);
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(adc_req), 0);
    chk("arst_valid", 32'(sample_valid), 0);
    check_outputs("arst", '0, '0, '0, '0, 1'b0, 1'b0, '0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    run_scan(12'd3600, 12'd3601, 12'd3602, 8'd33, 1, -1, 1'b0);
    check_model("post_rst");

    tick(); tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
